// File: rtl/bitstream_matcher_pkg.sv
// Shared types and encodings for the bitstream_matcher frame comparator.
package bitstream_matcher_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/xnorgate.sv
// Two-input XNOR cell: f is high when a and b carry the same value.
module xnorgate (
    input  logic a,
    input  logic b,
    output logic f
);

    assign f = ~(a ^ b);

endmodule

// File: rtl/bitstream_matcher.sv
// Serial frame comparator: counts per-bit mismatches between streams a and b
// over FRAME_LEN valid bits and reports a registered pass/fail verdict.
module bitstream_matcher
    import bitstream_matcher_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_s;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] err_cnt_s;
    logic             match_r;
    logic             match_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic             eq_s;
    logic             mis_s;

    xnorgate u_xnor (
        .a (a),
        .b (b),
        .f (eq_s)
    );

    // Kept as a 1-bit net so the widening below zero-extends rather than inverts.
    assign mis_s = ~eq_s;

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        err_cnt_s = err_cnt_r;
        match_s   = match_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s   = S_RUN;
                    bit_cnt_s = CNT_ZERO;
                    err_cnt_s = CNT_ZERO;
                    match_s   = 1'b0;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_RUN: begin
                if (valid) begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                    err_cnt_s = err_cnt_r + CNT_W'(mis_s);
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s = S_DONE;
                        match_s = (err_cnt_s == CNT_ZERO);
                    end else begin
                        state_s = S_RUN;
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s == S_RUN);
        done_s = (state_s == S_DONE);
    end

    // State, counters and all outputs are registered; reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            bit_cnt_r <= CNT_ZERO;
            err_cnt_r <= CNT_ZERO;
            match_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            err_cnt_r <= err_cnt_s;
            match_r   <= match_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign match   = match_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_bitstream_matcher.sv
// Directed self-checking bench for bitstream_matcher (FRAME_LEN=8, CNT_W=4).
module tb_bitstream_matcher;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       valid;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       match;
    logic [3:0] err_cnt;

    int n_vec;
    int n_bad;

    bitstream_matcher #(.FRAME_LEN(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .valid   (valid),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .match   (match),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame. vpat gives per-cycle valid (MSB = first cycle after start).
    // start_valid drives a mismatching bit alongside start; start_at pulses start mid-run.
    task automatic run_frame(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic [15:0] vpat, input logic start_valid, input int start_at,
                             input int exp_edges, input int exp_err, input logic exp_match);
        int idx;
        int run_err;
        int edges;
        logic seen;
        idx = 7;
        run_err = 0;
        edges = 0;
        seen = 1'b0;
        start = 1'b1;
        valid = start_valid;
        a = 1'b1;
        b = 1'b0;
        tick();
        check_val({name, ".busy_at_start"}, 32'(busy), 32'd1);
        check_val({name, ".err_cleared"}, 32'(err_cnt), 32'd0);
        start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            start = (c == start_at);
            valid = (c < 16) ? vpat[15-c] : 1'b0;
            a = av[idx];
            b = bv[idx];
            if (valid) begin
                if (av[idx] != bv[idx]) run_err++;
                if (idx > 0) idx--;
            end
            tick();
            edges = c + 1;
            if (done) begin
                seen = 1'b1;
            end else if (valid && start_at < 0) begin
                check_val({name, ".live_err"}, 32'(err_cnt), 32'(run_err));
            end
        end
        start = 1'b0;
        check_val({name, ".done_seen"}, 32'(seen), 32'd1);
        check_val({name, ".done_edges"}, 32'(edges), 32'(exp_edges));
        check_val({name, ".busy_in_done"}, 32'(busy), 32'd0);
        check_val({name, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check_val({name, ".match"}, 32'(match), 32'(exp_match));
        // valid with a mismatch in the DONE cycle must be ignored
        valid = 1'b1;
        a = 1'b0;
        b = 1'b1;
        tick();
        valid = 1'b0;
        check_val({name, ".done_pulse"}, 32'(done), 32'd0);
        check_val({name, ".hold_err"}, 32'(err_cnt), 32'(exp_err));
        check_val({name, ".hold_match"}, 32'(match), 32'(exp_match));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        a = 1'b0;
        b = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            valid = 1'($urandom);
            a = 1'($urandom);
            b = 1'($urandom);
            tick();
        end
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.done", 32'(done), 32'd0);
        check_val("rst.match", 32'(match), 32'd0);
        check_val("rst.err_cnt", 32'(err_cnt), 32'd0);
        start = 1'b0;
        valid = 1'b0;
        rst_n = 1'b1;
        tick();

        run_frame("equal", 8'b10110010, 8'b10110010, 16'hFF00, 1'b0, -1, 8, 0, 1'b1);
        tick();
        run_frame("allmis", 8'hFF, 8'h00, 16'hFF00, 1'b0, -1, 8, 8, 1'b0);
        tick();
        run_frame("gaps", 8'hA5, 8'hA4, 16'b1101_1011_1010_0000, 1'b0, -1, 11, 1, 1'b0);

        // results hold through idle cycles with stray valid bits
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            a = 1'b1;
            b = 1'b0;
            tick();
        end
        valid = 1'b0;
        check_val("idle.hold_err", 32'(err_cnt), 32'd1);
        check_val("idle.hold_match", 32'(match), 32'd0);
        check_val("idle.busy", 32'(busy), 32'd0);

        run_frame("start_valid", 8'h3C, 8'h3C, 16'hFF00, 1'b1, -1, 8, 0, 1'b1);
        tick();
        run_frame("start_mid", 8'h5A, 8'h5A, 16'hFF00, 1'b0, 3, 8, 0, 1'b1);
        tick();

        // reset mid-frame after 5 bits with 2 mismatches
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            a = 1'b1;
            b = (i < 2) ? 1'b1 : ((i < 4) ? 1'b0 : 1'b1);
            tick();
        end
        valid = 1'b0;
        check_val("midrst.err_before", 32'(err_cnt), 32'd2);
        check_val("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst.busy", 32'(busy), 32'd0);
        check_val("midrst.done", 32'(done), 32'd0);
        check_val("midrst.match", 32'(match), 32'd0);
        check_val("midrst.err_cnt", 32'(err_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_frame("after_rst", 8'hC3, 8'hC3, 16'hFF00, 1'b0, -1, 8, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
